// File: rtl/rtob_sched_pkg.sv
// Shared types and helpers for the RTOB write-port scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, entry layout constants, ts_of() timestamp extractor.
package rtob_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FLUSH = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam int TS_MSB = 127;
  localparam int TS_LSB = 64;
  localparam int DATA_W = 128;
  localparam int TS_W   = TS_MSB - TS_LSB + 1;

  function automatic logic [TS_W-1:0] ts_of(input logic [DATA_W-1:0] entry);
    return entry[TS_MSB:TS_LSB];
  endfunction

endpackage

// File: rtl/rtob_min_ts_select.sv
// Picks the valid head with the smallest timestamp; ties go to the first requester at or after i_rr_ptr.
// Latency: purely combinational.
// Backpressure: none here; the caller gates the one-hot winner.
//
// Ports: i_valid   - per-requester head valid
//        i_data    - head entries, requester j at [DATA_W*j +: DATA_W]
//        i_rr_ptr  - requester with highest tie-break priority
//        o_winner  - one-hot winner (all zero when nothing is valid)
//        o_any_valid - at least one head is valid
module rtob_min_ts_select
  import rtob_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0]        i_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_data,
  input  logic [PTR_W-1:0]          i_rr_ptr,
  output logic [NUM_REQ-1:0]        o_winner,
  output logic                      o_any_valid
);

  logic            w_found;
  logic [TS_W-1:0] w_ts;
  logic [TS_W-1:0] w_best_ts;
  logic [PTR_W:0]  w_dist;
  logic [PTR_W:0]  w_best_dist;

  // Ordering key is {timestamp, distance from rr pointer}; the smaller key wins,
  // so equal timestamps fall to the requester closest after the pointer.
  always_comb begin
    o_winner    = '0;
    w_found     = 1'b0;
    w_ts        = '0;
    w_best_ts   = '0;
    w_dist      = '0;
    w_best_dist = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_ts = ts_of(i_data[DATA_W*j +: DATA_W]);
      if ({1'b0, i_rr_ptr} <= (PTR_W+1)'(j))
        w_dist = (PTR_W+1)'(j) - {1'b0, i_rr_ptr};
      else
        w_dist = (PTR_W+1)'(j + NUM_REQ) - {1'b0, i_rr_ptr};
      if (i_valid[j] && (!w_found || (w_ts < w_best_ts) ||
                         ((w_ts == w_best_ts) && (w_dist < w_best_dist)))) begin
        o_winner    = '0;
        o_winner[j] = 1'b1;
        w_found     = 1'b1;
        w_best_ts   = w_ts;
        w_best_dist = w_dist;
      end
    end
    o_any_valid = w_found;
  end

endmodule

// File: rtl/rtob_sched_arbiter.sv
// Shares the RTOB_Core write port among NUM_REQ producers (earliest timestamp first) and sequences the core.
// Latency: grant in cycle t -> o_core_write/o_core_fifo_din in cycle t+1.
// Backpressure: i_core_full (prog_full) blocks new grants; the one write already in flight still lands.
//
// Ports: i_clk, i_reset (sync, active-high)
//        i_req_valid/i_req_data/o_req_ready - producer heads, one-hot consume
//        i_cmd_start/i_cmd_stop/i_cmd_flush - control pulses
//        o_core_write/o_core_fifo_din/o_core_auto_start/o_core_flush - to RTOB_Core
//        i_core_full/i_core_empty/i_core_ts_error/i_core_ovf_error - from RTOB_Core
//        o_state - FSM state, o_err_count - saturating error-cycle count
// Optional build macro RTOB_SCHED_MONOTONIC_CHECK_EN: drop (but consume) winners older than the last write.
module rtob_sched_arbiter
  import rtob_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int FLUSH_CYCLES  = 4,
  parameter bit HALT_ON_ERROR = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic                      i_cmd_start,
  input  logic                      i_cmd_stop,
  input  logic                      i_cmd_flush,
  output logic                      o_core_write,
  output logic [DATA_W-1:0]         o_core_fifo_din,
  output logic                      o_core_auto_start,
  output logic                      o_core_flush,
  input  logic                      i_core_full,
  input  logic                      i_core_empty,
  input  logic                      i_core_ts_error,
  input  logic                      i_core_ovf_error,
  output logic [2:0]                o_state,
  output logic [15:0]               o_err_count
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

  state_t              r_state, w_state_nxt;
  logic [PTR_W-1:0]    r_rr_ptr, w_rr_nxt;
  logic [FC_W-1:0]     r_flush_cnt;
  logic                r_core_write;
  logic [DATA_W-1:0]   r_core_din;
  logic [15:0]         r_err_count;

  logic [NUM_REQ-1:0]  w_winner;
  logic                w_any_valid;
  logic                w_grant_en;
  logic                w_grant;
  logic [DATA_W-1:0]   w_win_data;
  logic                w_core_err;
  logic                w_mono_err;
  logic                w_flush_done;
  logic                w_to_flush;
  logic [16:0]         w_err_sum;

  assign w_core_err   = i_core_ts_error | i_core_ovf_error;
  assign w_flush_done = (r_flush_cnt == FC_W'(FLUSH_CYCLES - 1));
  assign w_to_flush   = (w_state_nxt == ST_FLUSH);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state plus the state-decoded controls; flush outranks everything.
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_en        = 1'b0;
    o_core_auto_start = 1'b0;
    o_core_flush      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_grant_en = ~i_core_full;
        if (i_cmd_start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_grant_en        = ~i_core_full;
        o_core_auto_start = 1'b1;
        if (HALT_ON_ERROR && w_core_err) w_state_nxt = ST_ERROR;
        else if (i_cmd_stop)             w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        o_core_auto_start = 1'b1;
        if (HALT_ON_ERROR && w_core_err) w_state_nxt = ST_ERROR;
        else if (i_core_empty)           w_state_nxt = ST_IDLE;
      end
      ST_FLUSH: begin
        o_core_flush = 1'b1;
        if (w_flush_done) w_state_nxt = ST_IDLE;
      end
      ST_ERROR: ;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_cmd_flush) w_state_nxt = ST_FLUSH;
  end

  // A repeated flush command restarts the hold period.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_cmd_flush)    r_flush_cnt <= '0;
    else if (r_state == ST_FLUSH)  r_flush_cnt <= r_flush_cnt + 1'b1;
  end

  rtob_min_ts_select #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_sel (
    .i_valid     (i_req_valid),
    .i_data      (i_req_data),
    .i_rr_ptr    (r_rr_ptr),
    .o_winner    (w_winner),
    .o_any_valid (w_any_valid)
  );

  assign w_grant     = w_grant_en & w_any_valid;
  assign o_req_ready = w_grant ? w_winner : '0;

  always_comb begin
    w_win_data = '0;
    w_rr_nxt   = r_rr_ptr;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_winner[j]) begin
        w_win_data = w_win_data | i_req_data[DATA_W*j +: DATA_W];
        w_rr_nxt   = (j == NUM_REQ - 1) ? '0 : PTR_W'(j + 1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || w_to_flush) r_rr_ptr <= '0;
    else if (w_grant)          r_rr_ptr <= w_rr_nxt;
  end

`ifdef RTOB_SCHED_MONOTONIC_CHECK_EN
  logic [TS_W-1:0] r_last_ts;

  assign w_mono_err = w_grant && (ts_of(w_win_data) < r_last_ts);

  always_ff @(posedge i_clk) begin
    if (i_reset || w_to_flush)     r_last_ts <= '0;
    else if (w_grant && !w_mono_err) r_last_ts <= ts_of(w_win_data);
  end
`else
  assign w_mono_err = 1'b0;
`endif

  // Any write registered on the way into FLUSH is dropped, not delivered.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_to_flush) begin
      r_core_write <= 1'b0;
      r_core_din   <= '0;
    end else begin
      r_core_write <= w_grant & ~w_mono_err;
      r_core_din   <= (w_grant & ~w_mono_err) ? w_win_data : '0;
    end
  end

  assign w_err_sum = {1'b0, r_err_count} + 17'(w_core_err) + 17'(w_mono_err);

  always_ff @(posedge i_clk) begin
    if (i_reset)          r_err_count <= '0;
    else if (w_err_sum[16]) r_err_count <= 16'hFFFF;
    else                  r_err_count <= w_err_sum[15:0];
  end

  assign o_core_write    = r_core_write;
  assign o_core_fifo_din = r_core_din;
  assign o_state         = r_state;
  assign o_err_count     = r_err_count;

endmodule
